// File: rtl/sbus_arb_pkg.sv
// Shared types and helpers for the sbus_arb shared-bus arbiter.
package sbus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int SBUS_ARB_MAX_MST = 8;

  // Width of a master index; a single master still needs a 1-bit field.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (a + b) mod n for a, b already in 0..n-1, without a divider.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/sbus_arb_rr_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr, wrapping.
module rr_pick
  import sbus_arb_pkg::*;
#(
  parameter int N_MST = 2,
  parameter int IW    = idx_w(N_MST)
) (
  input  logic [N_MST-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             any
);

  always_comb begin
    // NOTE: every output gets a default before the search loop so no path leaves it unassigned (no latch).
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N_MST; k++) begin
      if (!any && req[wrap_add(int'(ptr), k, N_MST)]) begin
        any = 1'b1;
        idx = IW'(wrap_add(int'(ptr), k, N_MST));
      end
    end
  end

endmodule

// File: rtl/sbus_arb.sv
// N-master to single-slave bus arbiter with registered downstream request.
// Define SBUS_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module sbus_arb
  import sbus_arb_pkg::*;
#(
  parameter int N_MST = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_MST-1:0]      m_req,
  input  logic [N_MST-1:0]      m_we,
  input  logic [N_MST*AW-1:0]   m_addr,
  input  logic [N_MST*DW-1:0]   m_wdat,
  input  logic [N_MST*DW/8-1:0] m_wsel,
  output logic [N_MST-1:0]      m_ack,
  output logic [DW-1:0]         m_rdat,
  output logic                  s_req,
  output logic                  s_we,
  output logic [AW-1:0]         s_addr,
  output logic [DW-1:0]         s_wdat,
  output logic [DW/8-1:0]       s_wsel,
  input  logic                  s_ack,
  input  logic [DW-1:0]         s_rdat
);

  localparam int IW = idx_w(N_MST);
  localparam int SW = DW / 8;

  if (N_MST < 1 || N_MST > SBUS_ARB_MAX_MST) begin : g_bad_n_mst
    $error("sbus_arb: N_MST out of range 1..%0d", SBUS_ARB_MAX_MST);
  end

  arb_state_t    state, state_next;
  logic [IW-1:0] owner;
  logic [IW-1:0] search_base;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          done;

  assign done = (state == BUSY) && s_ack;

`ifdef SBUS_ARB_FIXED_PRIO_EN
  // Searching from index 0 every time is exactly lowest-index-wins.
  assign search_base = '0;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      search_base <= '0;
    end else if (done) begin
      search_base <= IW'(wrap_add(int'(owner), 1, N_MST));
    end
  end
`endif

  rr_pick #(
    .N_MST(N_MST),
    .IW   (IW)
  ) u_pick (
    .req(m_req),
    .ptr(search_base),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_any) state_next = BUSY;
      BUSY:    if (s_ack)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= '0;
      s_req  <= 1'b0;
      s_we   <= 1'b0;
      s_addr <= '0;
      s_wdat <= '0;
      s_wsel <= '0;
    end else if (state == IDLE && pick_any) begin
      owner  <= pick_idx;
      s_req  <= 1'b1;
      s_we   <= m_we[pick_idx];
      s_addr <= m_addr[int'(pick_idx)*AW +: AW];
      s_wdat <= m_wdat[int'(pick_idx)*DW +: DW];
      s_wsel <= m_wsel[int'(pick_idx)*SW +: SW];
    end else if (done) begin
      s_req <= 1'b0;
    end
  end

  // Ack is combinational from s_ack so a zero-wait slave completes in one cycle.
  always_comb begin
    m_ack = '0;
    if (!rst && done) m_ack = N_MST'(1) << owner;
  end

  assign m_rdat = s_rdat;

endmodule

// File: tb/tb_sbus_arb.sv
// Scoreboard bench for sbus_arb (N_MST=4): directed transactions, monitor checks on every ack.
module tb_sbus_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] RD_KEY = 32'h5A5A_C3C3;

  typedef struct {
    int          mst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  wsel;
    logic [31:0] rdat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdat;
  logic [N*4-1:0]  m_wsel;
  logic [N-1:0]    m_ack;
  logic [DW-1:0]   m_rdat;
  logic            s_req, s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdat;
  logic [3:0]      s_wsel;
  logic            s_ack = 1'b0;
  logic [DW-1:0]   s_rdat = '0;

  logic [31:0] addr_a [N];
  logic [31:0] wdat_a [N];
  logic [3:0]  wsel_a [N];
  logic        we_a   [N];
  logic        abandon[N];
  int          issued [N];
  int          done_cnt[N];

  int   slave_wait = 0;
  logic rd_override = 1'b0;
  int   stray_req = 0;
  int   stray_served = 0;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  sbus_arb #(.N_MST(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdat(m_wdat), .m_wsel(m_wsel),
    .m_ack(m_ack), .m_rdat(m_rdat),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdat(s_wdat), .s_wsel(s_wsel),
    .s_ack(s_ack), .s_rdat(s_rdat)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_req[i]            = (issued[i] != done_cnt[i]) && !abandon[i];
      m_we[i]             = we_a[i];
      m_addr[i*AW +: AW]  = addr_a[i];
      m_wdat[i*DW +: DW]  = wdat_a[i];
      m_wsel[i*4 +: 4]    = wsel_a[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic set_fields(input int i, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] sel);
    we_a[i] = we; addr_a[i] = a; wdat_a[i] = d; wsel_a[i] = sel;
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.mst = i; e.we = we_a[i]; e.addr = addr_a[i]; e.wdat = wdat_a[i]; e.wsel = wsel_a[i];
    e.rdat = rd_override ? 32'hDEAD_BEEF : (addr_a[i] ^ RD_KEY);
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !s_req) ok = 1'b1;
    end
    if (!ok) check("wait_idle_timeout_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Slave model: acks after slave_wait cycles of s_req, read data derived from address.
  initial begin
    int wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (s_ack) begin
        s_ack = 1'b0;
      end else if (stray_served != stray_req) begin
        stray_served++;
        s_ack  = 1'b1;
        s_rdat = 32'h0BAD_0BAD;
      end else if (s_req) begin
        if (wcnt >= slave_wait) begin
          s_ack  = 1'b1;
          s_rdat = rd_override ? 32'hDEAD_BEEF : (s_addr ^ RD_KEY);
          wcnt   = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Master side: each ack retires one outstanding request of that master.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (m_ack[i]) done_cnt[i]++;
    end
  end

  // Monitor: s_* must match the expected head while busy; each ack pops one entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (s_req && !rst && exp_q.size() > 0) begin
        e = exp_q[0];
        check("s_addr", 64'(s_addr), 64'(e.addr));
        check("s_we",   64'(s_we),   64'(e.we));
        check("s_wdat", 64'(s_wdat), 64'(e.wdat));
        check("s_wsel", 64'(s_wsel), 64'(e.wsel));
      end
      if (m_ack != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_m_ack", 64'(m_ack), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("m_ack_owner", 64'(m_ack), 64'(1) << e.mst);
          check("m_rdat", 64'(m_rdat), 64'(e.rdat));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      set_fields(i, 1'b0, '0, '0, '0);
      abandon[i] = 1'b0; issued[i] = 0; done_cnt[i] = 0;
    end

    // Reset state and quiet idle.
    repeat (3) @(negedge clk);
    check("rst_s_req",  64'(s_req),  64'd0);
    check("rst_s_we",   64'(s_we),   64'd0);
    check("rst_s_addr", 64'(s_addr), 64'd0);
    check("rst_s_wdat", 64'(s_wdat), 64'd0);
    check("rst_s_wsel", 64'(s_wsel), 64'd0);
    check("rst_m_ack",  64'(m_ack),  64'd0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_s_req", 64'(s_req), 64'd0);
      check("idle_m_ack", 64'(m_ack), 64'd0);
    end

    // Masters 0 and 1 requesting continuously, zero-wait slave.
    slave_wait = 0;
    set_fields(0, 1'b1, 32'h0000_0100, 32'h1111_0000, 4'hF);
    set_fields(1, 1'b0, 32'h0000_0200, 32'h2222_0000, 4'h0);
`ifdef SBUS_ARB_FIXED_PRIO_EN
    push_exp(0); push_exp(0); push_exp(0); push_exp(1); push_exp(1); push_exp(1);
`else
    push_exp(0); push_exp(1); push_exp(0); push_exp(1); push_exp(0); push_exp(1);
`endif
    issued[0] += 3; issued[1] += 3;
    wait_idle();

    // Master 1 read with three wait states; s_req must rise one cycle after the request.
    slave_wait = 3;
    rd_override = 1'b1;
    set_fields(1, 1'b0, 32'h1000_0040, 32'h0, 4'h0);
    push_exp(1);
    issued[1]++;
    @(negedge clk);
    check("latency_s_req", 64'(s_req), 64'd1);
    wait_idle();
    rd_override = 1'b0;

    // Master 2 alone moves the pointer to 3; then 0 and 2 together: 0 wins by wrap.
    slave_wait = 0;
    set_fields(2, 1'b1, 32'h2000_0008, 32'hCAFE_F00D, 4'b0011);
    push_exp(2);
    issued[2]++;
    wait_idle();
    set_fields(0, 1'b1, 32'h3000_0000, 32'hA0A0_A0A0, 4'b1000);
    set_fields(2, 1'b0, 32'h2000_0010, 32'h0, 4'h0);
    push_exp(0); push_exp(2);
    issued[0]++; issued[2]++;
    wait_idle();

    // Owner drops its request mid-transaction; it must still complete.
    slave_wait = 2;
    set_fields(3, 1'b1, 32'h4000_0004, 32'h0BAD_F00D, 4'b0101);
    push_exp(3);
    issued[3]++;
    @(negedge clk);
    abandon[3] = 1'b1;
    wait_idle();
    abandon[3] = 1'b0;

    // Master 1 alone leaves the pointer at 2 before the reset test.
    slave_wait = 0;
    set_fields(1, 1'b1, 32'h5000_0000, 32'h1234_5678, 4'hF);
    push_exp(1);
    issued[1]++;
    wait_idle();

    // Reset in BUSY abandons master 2; a stray ack afterwards does nothing.
    slave_wait = 6;
    set_fields(2, 1'b1, 32'h6000_0000, 32'hFFFF_0000, 4'hF);
    issued[2]++;
    @(negedge clk);
    check("busy_before_rst", 64'(s_req), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    abandon[2] = 1'b1;
    @(negedge clk);
    check("rst_busy_m_ack", 64'(m_ack), 64'd0);
    check("rst_busy_s_req", 64'(s_req), 64'd0);
    rst = 1'b0;
    slave_wait = 0;
    stray_req++;
    @(negedge clk);
    check("stray_m_ack", 64'(m_ack), 64'd0);
    @(negedge clk);
    check("stray_s_req", 64'(s_req), 64'd0);

    // After reset the pointer is 0: masters 1 and 3 together give 1 first.
    set_fields(1, 1'b0, 32'h7000_0010, 32'h0, 4'h0);
    set_fields(3, 1'b1, 32'h7000_0030, 32'h7777_3333, 4'b1100);
    push_exp(1); push_exp(3);
    issued[1]++; issued[3]++;
    wait_idle();

    repeat (3) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sbus_arb.md
SBUS_ARB -- requirements
Module: sbus_arb

Interface
- REQ-001 SHALL have parameter N_MST, default 2, meaning the number of master channels (legal range 1..8).
- REQ-002 SHALL have parameter AW, default 32, meaning the address width.
- REQ-003 SHALL have parameter DW, default 32, meaning the data width (multiple of 8).
- REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
- REQ-005 SHALL have ports: rst  in  1  synchronous, active-high reset.
- REQ-006 SHALL have ports: m_req  in  N_MST  per-master request, held until that master's ack.
- REQ-007 SHALL have ports: m_we  in  N_MST  per-master write flag.
- REQ-008 SHALL have ports: m_addr  in  N_MST*AW  per-master address; master i occupies slice i.
- REQ-009 SHALL have ports: m_wdat  in  N_MST*DW  per-master write data.
- REQ-010 SHALL have ports: m_wsel  in  N_MST*DW/8  per-master byte enables.
- REQ-011 SHALL have ports: m_ack  out  N_MST  one-cycle completion pulse to the owning master.
- REQ-012 SHALL have ports: m_rdat  out  DW  read data, valid only where the m_ack bit is high.
- REQ-013 SHALL have ports: s_req, s_we, s_addr, s_wdat, s_wsel  out  1/1/AW/DW/DW/8  downstream request fields.
- REQ-014 SHALL have ports: s_ack  in  1  downstream completion pulse.
- REQ-015 SHALL have ports: s_rdat  in  DW  downstream read data, qualified by s_ack.

Function
- REQ-016 SHALL implement a two-state FSM: IDLE and BUSY.
- REQ-017 IDLE: if any m_req bit is high, SHALL select a winner, register its index in owner, register its request fields into the s_* outputs, and go to BUSY on the next edge; otherwise SHALL remain in IDLE.
- REQ-018 BUSY: SHALL hold s_req=1 with all s_* fields stable until s_ack=1.
- REQ-019 On s_ack in BUSY, SHALL assert m_ack[owner] combinationally in the same cycle, drive m_rdat=s_rdat, deassert s_req on the next edge, and return to IDLE.
- REQ-020 Latency: request seen in cycle t SHALL produce s_req=1 at t+1; a zero-wait slave acking at t+1 SHALL give m_ack at t+1; a master's back-to-back issue rate SHALL be one transaction per 2 cycles minimum.
- REQ-021 Default arbitration SHALL be round-robin: search starts at ptr, wraps modulo N_MST, and takes the first requesting index.
- REQ-022 On each completed transaction, ptr SHALL be set to (owner+1) mod N_MST; index N_MST-1 SHALL wrap to 0.
- REQ-023 m_ack bits other than owner SHALL be 0 at all times; all m_ack bits SHALL be 0 in IDLE.
- REQ-024 s_ack arriving in IDLE SHALL be ignored, with no m_ack and no state change.
- REQ-025 A requester dropping m_req while it is owner SHALL NOT abort the transaction, which completes and acks normally.
- REQ-026 Requests arriving in BUSY SHALL wait, with no reordering of the current owner.
- REQ-027 With N_MST=1, the block SHALL behave as a registered pass-through; ptr is constant 0.

Reset
- REQ-028 On rst=1 at a clock edge, SHALL set state=IDLE, ptr=0, owner=0, s_req=0, s_we=0, s_addr=0, s_wdat=0, s_wsel=0; m_ack SHALL be 0 while rst=1.
- REQ-029 Reset mid-BUSY SHALL abandon the transaction without emitting m_ack; a later stray s_ack is handled per REQ-024.

Configuration
- REQ-030 Macro SBUS_ARB_FIXED_PRIO_EN: when defined, lowest requesting index SHALL always win and ptr SHALL be removed; when undefined, round-robin per REQ-021/022 applies.

Structure
- REQ-031 Package includes SHALL hold typedef arb_state_t (IDLE, BUSY) and constant SBUS_ARB_MAX_MST=8.
- REQ-032 Winner selection SHALL be a combinational sub-module rr_pick (inputs req vector and ptr; outputs index and any), instantiated once.

Verification
- REQ-033 Reset then idle: no m_req for 10 cycles -> s_req=0, m_ack=0 throughout.
- REQ-034 N_MST=2, zero-wait slave, both masters requesting continuously -> grants alternate 0,1,0,1; each m_ack exactly one cycle.
- REQ-035 Master 1 read of addr 0x1000_0040, slave acks after 3 wait cycles with s_rdat=0xDEADBEEF -> m_ack[1] pulse, m_rdat=0xDEADBEEF, s_* stable during wait.
- REQ-036 N_MST=4, ptr=3, requests on 0 and 2 -> 0 wins (wrap), then 2.
- REQ-037 rst pulsed in BUSY, followed by stray s_ack -> no m_ack, state IDLE, ptr=0.
- REQ-038 SBUS_ARB_FIXED_PRIO_EN defined, masters 0 and 1 requesting continuously -> master 0 wins every arbitration.
